// File: rtl/idma_txrx_write_mch_if.sv
// Bundle of the write-channel handshakes: AW request, W datapath beat, response,
// buffer read side and the per-channel peripheral TX outputs.
// slave = the write engine's view, master = the surrounding datapath/peripherals.
interface idma_txrx_write_mch_if #(
    parameter int unsigned StrbWidth = 16,
    parameter int unsigned NumChan   = 4,
    parameter int unsigned LenWidth  = 8
);
    localparam int unsigned ChanW = (NumChan > 1) ? $clog2(NumChan) : 1;
    localparam int unsigned OffW  = $clog2(StrbWidth);

    // AW request
    logic                            aw_valid_i;
    logic                            aw_ready_o;
    logic [ChanW-1:0]                aw_chan_i;
    logic [LenWidth-1:0]             aw_len_i;
    // W datapath beat
    logic                            w_dp_valid_i;
    logic                            w_dp_ready_o;
    logic [OffW-1:0]                 w_dp_offset_i;
    logic [OffW-1:0]                 w_dp_tailer_i;
    logic                            dp_poison_i;
    // Burst response
    logic                            w_dp_rsp_valid_o;
    logic                            w_dp_rsp_ready_i;
    logic [LenWidth:0]               w_dp_rsp_beats_o;
    logic                            w_dp_rsp_error_o;
    // Byte buffer read side
    logic [8*StrbWidth-1:0]          buffer_out_i;
    logic [StrbWidth-1:0]            buffer_out_valid_i;
    logic [StrbWidth-1:0]            buffer_out_ready_o;
    // Peripheral TX channels
    logic [NumChan-1:0]              tx_req_i;
    logic [NumChan-1:0]              tx_ready_i;
    logic [NumChan-1:0]              tx_valid_o;
    logic [NumChan*8*StrbWidth-1:0]  tx_data_o;
    logic                            busy_o;

    modport slave (
        input  aw_valid_i, aw_chan_i, aw_len_i,
        input  w_dp_valid_i, w_dp_offset_i, w_dp_tailer_i, dp_poison_i,
        input  w_dp_rsp_ready_i,
        input  buffer_out_i, buffer_out_valid_i,
        input  tx_req_i, tx_ready_i,
        output aw_ready_o, w_dp_ready_o,
        output w_dp_rsp_valid_o, w_dp_rsp_beats_o, w_dp_rsp_error_o,
        output buffer_out_ready_o,
        output tx_valid_o, tx_data_o, busy_o
    );

    modport master (
        output aw_valid_i, aw_chan_i, aw_len_i,
        output w_dp_valid_i, w_dp_offset_i, w_dp_tailer_i, dp_poison_i,
        output w_dp_rsp_ready_i,
        output buffer_out_i, buffer_out_valid_i,
        output tx_req_i, tx_ready_i,
        input  aw_ready_o, w_dp_ready_o,
        input  w_dp_rsp_valid_o, w_dp_rsp_beats_o, w_dp_rsp_error_o,
        input  buffer_out_ready_o,
        input  tx_valid_o, tx_data_o, busy_o
    );
endinterface

// File: rtl/idma_txrx_write_mch.sv
// Write engine: moves masked buffer beats of one burst through a small FIFO to a selected TX channel.
// Latency: beat accepted in cycle N appears as tx_valid_o in cycle N+1 (no FIFO bypass).
// Backpressure: beats stall while the FIFO is full; the FIFO drains only on tx_req & tx_ready of the burst's channel.
// Optional DRAIN watchdog enabled by defining IDMA_TXRX_WRITE_TIMEOUT_EN.
module idma_txrx_write_mch #(
    parameter int unsigned StrbWidth       = 16,
    parameter int unsigned NumChan         = 4,
    parameter int unsigned FifoDepth       = 4,
    parameter int unsigned LenWidth        = 8,
    parameter bit          MaskInvalidData = 1'b1,
    parameter int unsigned TimeoutCycles   = 1024
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    idma_txrx_write_mch_if.slave  bus
);
    localparam int unsigned ChanW = (NumChan > 1) ? $clog2(NumChan) : 1;
    localparam int unsigned OffW  = $clog2(StrbWidth);
    localparam int unsigned DataW = 8 * StrbWidth;
    localparam int unsigned PtrW  = $clog2(FifoDepth);
    localparam int unsigned CntW  = PtrW + 1;
    localparam int unsigned BeatW = LenWidth + 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BURST = 2'd1,
        DRAIN = 2'd2,
        RESP  = 2'd3
    } state_e;

    // Bytes [offset, tailer) are valid; tailer==0 means "up to the end of the beat".
    function automatic logic [StrbWidth-1:0] beat_mask(input logic [OffW-1:0] off,
                                                       input logic [OffW-1:0] tail);
        logic [StrbWidth-1:0] ones;
        logic [StrbWidth-1:0] lo;
        logic [StrbWidth-1:0] hi;
        ones = '1;
        lo   = ones << off;
        hi   = (tail != '0) ? (ones >> (StrbWidth - 32'(tail))) : ones;
        return lo & hi;
    endfunction

    state_e               state_q, state_d;
    logic [ChanW-1:0]     chan_q, chan_d;
    logic [LenWidth-1:0]  rem_q, rem_d;
    logic                 err_q, err_d;
    logic [BeatW-1:0]     dlv_q, dlv_d;

    logic [DataW-1:0]     mem_q [FifoDepth];
    logic [PtrW-1:0]      wr_ptr_q, rd_ptr_q;
    logic [CntW-1:0]      cnt_q;

    logic [StrbWidth-1:0] mask;
    logic [DataW-1:0]     push_data;
    logic                 fifo_full, fifo_empty;
    logic                 beat_ok, push, pop, flush, dlv_clr, to_hit;
    logic                 sel_req, sel_rdy;
    logic                 aw_ready, w_dp_ready, rsp_valid;
    logic [StrbWidth-1:0] buf_ready;
    logic [NumChan-1:0]   tx_valid;
    logic [NumChan*DataW-1:0] tx_data;

    assign mask       = beat_mask(bus.w_dp_offset_i, bus.w_dp_tailer_i);
    assign fifo_full  = (cnt_q == CntW'(FifoDepth));
    assign fifo_empty = (cnt_q == '0);
    assign beat_ok    = bus.w_dp_valid_i
                      && ((bus.buffer_out_valid_i & mask) == mask)
                      && (bus.buffer_out_valid_i != '0)
                      && !fifo_full;

    // Byte-lane masking of the incoming beat before it is stored
    always_comb begin
        push_data = bus.buffer_out_i;
        for (int b = 0; b < StrbWidth; b++) begin
            if (MaskInvalidData && !mask[b]) begin
                push_data[8*b +: 8] = 8'h00;
            end
        end
    end

    // Route the FIFO head to the burst's channel only; every other channel stays quiet
    always_comb begin
        tx_valid = '0;
        tx_data  = '0;
        sel_req  = 1'b0;
        sel_rdy  = 1'b0;
        for (int c = 0; c < NumChan; c++) begin
            if (ChanW'(c) == chan_q) begin
                tx_valid[c]              = !fifo_empty;
                tx_data[c*DataW +: DataW] = fifo_empty ? '0 : mem_q[rd_ptr_q];
                sel_req                  = bus.tx_req_i[c];
                sel_rdy                  = bus.tx_ready_i[c];
            end
        end
    end

    assign pop = sel_req && sel_rdy && !fifo_empty;

    // Burst control: next state, handshakes and burst bookkeeping
    always_comb begin
        state_d    = state_q;
        chan_d     = chan_q;
        rem_d      = rem_q;
        err_d      = err_q;
        dlv_clr    = 1'b0;
        push       = 1'b0;
        flush      = 1'b0;
        aw_ready   = 1'b0;
        w_dp_ready = 1'b0;
        buf_ready  = '0;
        rsp_valid  = 1'b0;
        unique case (state_q)
            IDLE: begin
                aw_ready = 1'b1;
                if (bus.aw_valid_i) begin
                    chan_d  = bus.aw_chan_i;
                    rem_d   = bus.aw_len_i;
                    err_d   = 1'b0;
                    dlv_clr = 1'b1;
                    state_d = BURST;
                end
            end
            BURST: begin
                if (beat_ok) begin
                    w_dp_ready = 1'b1;
                    buf_ready  = mask;
                    // A poisoned beat is consumed from the buffer but never forwarded
                    if (bus.dp_poison_i) begin
                        err_d = 1'b1;
                    end else begin
                        push = 1'b1;
                    end
                    if (rem_q == '0) begin
                        state_d = DRAIN;
                    end else begin
                        rem_d = rem_q - LenWidth'(1);
                    end
                end
            end
            DRAIN: begin
                if (to_hit) begin
                    flush   = 1'b1;
                    err_d   = 1'b1;
                    state_d = RESP;
                end else if (fifo_empty) begin
                    state_d = RESP;
                end
            end
            RESP: begin
                rsp_valid = 1'b1;
                if (bus.w_dp_rsp_ready_i) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign dlv_d = dlv_clr ? '0 : (pop ? dlv_q + BeatW'(1) : dlv_q);

    // Burst state and bookkeeping registers
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            chan_q  <= '0;
            rem_q   <= '0;
            err_q   <= 1'b0;
            dlv_q   <= '0;
        end else begin
            state_q <= state_d;
            chan_q  <= chan_d;
            rem_q   <= rem_d;
            err_q   <= err_d;
            dlv_q   <= dlv_d;
        end
    end

    // FIFO pointers and occupancy; a flush discards whatever is still queued
    always_ff @(posedge clk_i) begin
        if (rst_i || flush) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + PtrW'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PtrW'(1);
            end
            unique case ({push, pop})
                2'b10:   cnt_q <= cnt_q + CntW'(1);
                2'b01:   cnt_q <= cnt_q - CntW'(1);
                default: cnt_q <= cnt_q;
            endcase
        end
    end

    // FIFO storage; no reset needed because occupancy gates every read
    always_ff @(posedge clk_i) begin
        if (push) begin
            mem_q[wr_ptr_q] <= push_data;
        end
    end

`ifdef IDMA_TXRX_WRITE_TIMEOUT_EN
    localparam int unsigned ToW = $clog2(TimeoutCycles + 1);
    logic [ToW-1:0] to_cnt_q;

    assign to_hit = (state_q == DRAIN) && (to_cnt_q >= ToW'(TimeoutCycles));

    // Watchdog: restarts on any delivered beat or state change, counts only while draining
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            to_cnt_q <= '0;
        end else if (pop || (state_d != state_q)) begin
            to_cnt_q <= '0;
        end else if (state_q == DRAIN) begin
            to_cnt_q <= to_cnt_q + ToW'(1);
        end
    end
`else
    logic unused_timeout;
    assign to_hit         = 1'b0;
    assign unused_timeout = (TimeoutCycles != 0);
`endif

    assign bus.aw_ready_o         = aw_ready;
    assign bus.w_dp_ready_o       = w_dp_ready;
    assign bus.buffer_out_ready_o = buf_ready;
    assign bus.w_dp_rsp_valid_o   = rsp_valid;
    assign bus.w_dp_rsp_beats_o   = dlv_q;
    assign bus.w_dp_rsp_error_o   = err_q;
    assign bus.tx_valid_o         = tx_valid;
    assign bus.tx_data_o          = tx_data;
    assign bus.busy_o             = (state_q != IDLE);

endmodule
